// File: rtl/maquina_sw_frontend_if.sv
// Event handshake between the switch front-end and the machine core.
// The front-end presents one event code at a time; the core accepts it with ready.
interface maquina_sw_frontend_if;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ready;

   modport master (output evt_valid, evt_code, input evt_ready);
   modport slave  (input evt_valid, evt_code, output evt_ready);
endinterface

// File: rtl/maquina_sw_frontend.sv
// Switch front-end: synchronise and debounce P/R/N/D, turn each clean press into
// one event, and issue events one at a time in priority order R > P > D > N.
module maquina_sw_frontend #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            sw_raw,
   output logic [3:0]            sw_clean,
   output logic                  overflow,
   maquina_sw_frontend_if.master evt
);
   localparam int            CW      = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [3:0]    sync_q;
   logic [3:0]    s;
   logic [CW-1:0] cnt [4];
   logic [3:0]    rise;
   logic [3:0]    pend;
   logic [3:0]    clr;
   logic [3:0]    pend_nxt;
   logic          load;
   logic          ovf_hit;
   logic [1:0]    code_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s      <= '0;
      end else begin
         sync_q <= sw_raw;
         s      <= sync_q;
      end
   end

   // A level change is accepted on the DEB_CYCLES-th consecutive mismatching cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
         sw_clean <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s[i] == sw_clean[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               sw_clean[i] <= s[i];
               cnt[i]      <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         rise[i] = s[i] & ~sw_clean[i] & (cnt[i] == CNT_MAX);
   end

   // Bit map: [3]=P [2]=R [1]=N [0]=D; codes N=00 D=01 P=10 R=11.
   always_comb begin
      clr      = '0;
      code_nxt = 2'b00;
      load     = (|pend) && (!evt.evt_valid || evt.evt_ready);
      if (load) begin
         if (pend[2]) begin
            clr[2]   = 1'b1;
            code_nxt = 2'b11;
         end else if (pend[3]) begin
            clr[3]   = 1'b1;
            code_nxt = 2'b10;
         end else if (pend[0]) begin
            clr[0]   = 1'b1;
            code_nxt = 2'b01;
         end else begin
            clr[1]   = 1'b1;
            code_nxt = 2'b00;
         end
      end
      // A rise landing on the edge its own bit is loaded re-arms it (set wins).
      pend_nxt = (pend & ~clr) | rise;
      ovf_hit  = |(rise & pend & ~clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend          <= '0;
         overflow      <= 1'b0;
         evt.evt_valid <= 1'b0;
         evt.evt_code  <= 2'b00;
      end else begin
         pend <= pend_nxt;
         if (ovf_hit) overflow <= 1'b1;
         if (load) begin
            evt.evt_valid <= 1'b1;
            evt.evt_code  <= code_nxt;
         end else if (evt.evt_valid && evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_maquina_sw_frontend.sv
// Bench for maquina_sw_frontend: directed scenarios plus randomized switch/ready
// traffic, checked cycle by cycle against a behavioural model of the front-end.
module tb_maquina_sw_frontend;
   localparam int DEB = 4;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic [3:0] sw_raw = '0;
   logic [3:0] sw_clean;
   logic       overflow;
   int         checks   = 0;
   int         failures = 0;

   maquina_sw_frontend_if bus();

   maquina_sw_frontend #(.DEB_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw),
      .sw_clean (sw_clean),
      .overflow (overflow),
      .evt      (bus.master)
   );

   always #5 clk = ~clk;

   // Reference model: m_hist[k] holds the synchronised switch vector seen k edges ago.
   logic [3:0] m_s1, m_s, m_clean, m_pend;
   logic [3:0] m_hist [DEB];
   logic       m_valid, m_ovf;
   logic [1:0] m_code;
   int         prio_bit  [4] = '{2, 3, 0, 1};
   logic [1:0] prio_code [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
   logic [1:0] xfer_q [$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s = '0; m_clean = '0; m_pend = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_code = 2'b00;
      for (int k = 0; k < DEB; k++) m_hist[k] = '0;
   endtask

   task automatic model_step();
      logic [3:0] rise;
      logic [3:0] new_clean;
      logic [1:0] pick_code;
      bit         flip;
      int         pick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s;
      rise      = '0;
      new_clean = m_clean;
      // Level flips once the last DEB synchronised samples all disagree with it.
      for (int i = 0; i < 4; i++) begin
         flip = 1'b1;
         for (int k = 0; k < DEB; k++)
            if (m_hist[k][i] == m_clean[i]) flip = 1'b0;
         if (flip) begin
            new_clean[i] = ~m_clean[i];
            rise[i]      = ~m_clean[i];
         end
      end
      pick      = -1;
      pick_code = 2'b00;
      if (m_pend != 4'b0000 && (!m_valid || bus.evt_ready))
         for (int p = 0; p < 4; p++)
            if (pick < 0 && m_pend[prio_bit[p]]) begin
               pick      = prio_bit[p];
               pick_code = prio_code[p];
            end
      for (int i = 0; i < 4; i++)
         if (rise[i] && m_pend[i] && i != pick) m_ovf = 1'b1;
      if (pick >= 0) begin
         m_pend[pick] = 1'b0;
         m_valid      = 1'b1;
         m_code       = pick_code;
      end else if (m_valid && bus.evt_ready) begin
         m_valid = 1'b0;
      end
      m_pend  = m_pend | rise;
      m_clean = new_clean;
      m_s     = m_s1;
      m_s1    = sw_raw;
   endtask

   task automatic tick();
      if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) xfer_q.push_back(bus.evt_code);
      model_step();
      @(posedge clk);
      #1;
      check("sw_clean", 8'(sw_clean), 8'(m_clean));
      check("evt_valid", 8'(bus.evt_valid), 8'(m_valid));
      check("overflow", 8'(overflow), 8'(m_ovf));
      if (m_valid) check("evt_code", 8'(bus.evt_code), 8'(m_code));
   endtask

   task automatic start(input logic [3:0] sw, input logic rdy);
      sw_raw        = sw;
      bus.evt_ready = rdy;
      rst_n         = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      xfer_q.delete();
   endtask

   task automatic ticks_until_valid(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.evt_valid !== 1'b1 && n < limit);
   endtask

   // exp_packed lists expected codes first-event-first from bit 7 downwards.
   task automatic check_xfers(input string tag, input int n, input logic [7:0] exp_packed);
      check({tag, "_count"}, 8'(xfer_q.size()), 8'(n));
      for (int k = 0; k < n && k < xfer_q.size(); k++)
         check({tag, "_code"}, 8'(xfer_q[k]), 8'(exp_packed[7-2*k -: 2]));
   endtask

   initial begin
      int n;
      bus.evt_ready = 1'b0;

      // Reset with all switches held, then one event per switch in priority order.
      start(4'b1111, 1'b1);
      check("rst_sw_clean", 8'(sw_clean), 8'h00);
      check("rst_valid", 8'(bus.evt_valid), 8'h00);
      check("rst_code", 8'(bus.evt_code), 8'h00);
      check("rst_overflow", 8'(overflow), 8'h00);
      ticks_until_valid(20, n);
      check("t1_valid_edge", 8'(n), 8'd7);
      repeat (6) tick();
      check_xfers("t1_order", 4, 8'b11_10_01_00);
      check("t1_overflow", 8'(overflow), 8'h00);

      // Bounce rejection on N.
      start(4'b0000, 1'b1);
      for (int b = 0; b < 4; b++) begin
         sw_raw[1] = (b % 2 == 0);
         repeat (3) begin
            tick();
            check("t2_no_bounce", 8'(sw_clean[1]), 8'h00);
         end
      end
      sw_raw[1] = 1'b1;
      ticks_until_valid(20, n);
      check("t2_valid_edge", 8'(n), 8'd7);
      repeat (6) tick();
      check_xfers("t2_events", 1, 8'b00_000000);

      // Backpressure: D stalls, P pressed during the stall follows it.
      start(4'b0000, 1'b0);
      sw_raw = 4'b0001;
      ticks_until_valid(20, n);
      check("t3_valid_edge", 8'(n), 8'd7);
      for (int c = 0; c < 20; c++) begin
         if (c == 5) sw_raw = 4'b1001;
         tick();
         check("t3_hold_valid", 8'(bus.evt_valid), 8'h01);
         check("t3_hold_code", 8'(bus.evt_code), 8'h01);
      end
      bus.evt_ready = 1'b1;
      repeat (4) tick();
      check_xfers("t3_events", 2, 8'b01_10_0000);

      // Overflow: second P press while the first is still pending.
      start(4'b0000, 1'b0);
      sw_raw = 4'b0100; repeat (8) tick();
      sw_raw = 4'b1100; repeat (8) tick();
      check("t4_no_ovf_yet", 8'(overflow), 8'h00);
      sw_raw = 4'b0100; repeat (8) tick();
      sw_raw = 4'b1100; repeat (8) tick();
      check("t4_overflow", 8'(overflow), 8'h01);
      bus.evt_ready = 1'b1;
      repeat (6) tick();
      check_xfers("t4_events", 2, 8'b11_10_0000);
      sw_raw = 4'b0000; repeat (10) tick();
      check("t4_sticky", 8'(overflow), 8'h01);

      // Set-wins race: N re-rises on the edge it is loaded and R accepted.
      start(4'b0000, 1'b0);
      sw_raw = 4'b0110; repeat (8) tick();
      sw_raw = 4'b0100; repeat (8) tick();
      sw_raw = 4'b0110; repeat (5) tick();
      bus.evt_ready = 1'b1;
      tick();
      check("t5_race_code", 8'(bus.evt_code), 8'h00);
      repeat (5) tick();
      check_xfers("t5_events", 3, 8'b11_00_00_00);
      check("t5_overflow", 8'(overflow), 8'h00);

      // Asynchronous reset while an event is presented and others pend.
      start(4'b0000, 1'b0);
      sw_raw = 4'b1111; repeat (8) tick();
      check("t6_valid_before", 8'(bus.evt_valid), 8'h01);
      check("t6_code_before", 8'(bus.evt_code), 8'h03);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 8'(bus.evt_valid), 8'h00);
      check("t6_async_code", 8'(bus.evt_code), 8'h00);
      check("t6_async_clean", 8'(sw_clean), 8'h00);
      check("t6_async_ovf", 8'(overflow), 8'h00);
      model_reset();
      sw_raw = 4'b0000;
      tick();
      rst_n         = 1'b1;
      bus.evt_ready = 1'b1;
      xfer_q.delete();
      repeat (20) tick();
      check("t6_no_events", 8'(xfer_q.size()), 8'h00);

      // Randomized switch activity and ready, lockstep against the model.
      for (int blk = 0; blk < 4; blk++) begin
         start(4'b0000, 1'b1);
         for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
               if ($urandom_range(0, 5) == 0) sw_raw[i] = ~sw_raw[i];
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
